seg7_mux_driver: RTL

Time-multiplexed driver for a NUM_DIGITS common-anode/cathode 7-segment display. It captures a packed hex word and scans the digits one at a time at a programmable refresh rate, decoding each nibble to segments. Per-digit decimal point and blanking are supported, plus anti-ghosting dead time. It sits between the datapath/converters and the board display pins and replaces per-digit static decoders.

---
 rtl/seg7_mux_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed 7-segment display driver with shadow
// capture, dead time, blanking and optional leading-zero suppression (SEG7_LZS_EN).
module seg7_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_AN  = 0,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [4*NUM_DIGITS-1:0] r_val;
    logic [NUM_DIGITS-1:0]   r_dp_sh;
    logic [NUM_DIGITS-1:0]   r_blank_sh;
    logic [PW-1:0]           r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_wrap;
    logic                    w_dead;
    logic                    w_off;
    logic [3:0]              w_nib;
    logic                    w_sel_dp;
    logic                    w_sel_blank;
    logic                    w_sel_sup;
    logic [6:0]              w_seg_dec;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    // Hex nibble to {a..g}, a in the MSB, lit = 1.
    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            4'hF: s = 7'h47;
        endcase
        return s;
    endfunction

    // Shadow copy of the display data; the scanner never reads live inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val      <= '0;
            r_dp_sh    <= '0;
            r_blank_sh <= '0;
        end else if (load) begin
            r_val      <= value;
            r_dp_sh    <= dp_in;
            r_blank_sh <= blank_in;
        end
    end

    assign w_wrap = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_dead = (r_presc == '0);

    // Slot prescaler and digit pointer; pointer advances on the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_wrap ? '0 : r_presc + PW'(1);
            if (w_wrap) begin
                if (r_idx == IDX_W'(NUM_DIGITS - 1))
                    r_idx <= '0;
                else
                    r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

`ifdef SEG7_LZS_EN
    logic [NUM_DIGITS-1:0] w_sup;
    logic                  w_run;

    // Leading-zero chain: stays set from the top digit down while nibbles
    // are zero with no dp; digit 0 is never suppressed.
    always_comb begin
        w_sup = '0;
        w_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_run    = w_run && (r_val[4*i +: 4] == 4'h0) && !r_dp_sh[i];
            w_sup[i] = w_run;
        end
    end
`endif

    // Pick the nibble and per-digit flags of the digit being scanned.
    always_comb begin
        w_nib       = '0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_sup   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_val[4*i +: 4];
                w_sel_dp    = r_dp_sh[i];
                w_sel_blank = r_blank_sh[i];
`ifdef SEG7_LZS_EN
                w_sel_sup   = w_sup[i];
`endif
            end
        end
    end

    assign w_seg_dec = dec7(w_nib);
    assign w_off     = w_dead | w_sel_blank | w_sel_sup;
    assign w_seg_nxt = w_off ? 7'h00 : w_seg_dec;
    assign w_dp_nxt  = !w_off && w_sel_dp;

    // One-hot anode for the current digit, all off during the dead cycle.
    always_comb begin
        w_an_nxt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_nxt[i] = !w_dead && (r_idx == IDX_W'(i));
        end
    end

    // Output registers, kept in lit = 1 form until the pin inversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_dp  <= 1'b0;
            r_an  <= '0;
        end else begin
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg       = (ACTIVE_LOW_SEG != 0) ? ~r_seg : r_seg;
    assign dp        = (ACTIVE_LOW_SEG != 0) ? ~r_dp : r_dp;
    assign an        = (ACTIVE_LOW_AN != 0) ? ~r_an : r_an;
    assign digit_idx = r_idx;

endmodule
